// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: an ALU source and a data-memory source, each with a
// one-entry holding buffer, share one registered register-file write port.
module wb_port_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  input  logic [AW-1:0]       alu_addr,
  input  logic [DW-1:0]       alu_data,
  output logic                alu_ready,
  input  logic                dm_valid,
  input  logic [AW-1:0]       dm_addr,
  input  logic [DW-1:0]       dm_data,
  output logic                dm_ready,
  output logic                wb_en,
  output logic [AW-1:0]       wb_addr,
  output logic [DW-1:0]       wb_data,
  output logic [(2**AW)-1:0]  pend_mask,
  output logic [7:0]          conflict_cnt
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_DM = 1'b1} src_e;

  logic          alu_full_q, alu_full_d, alu_young_q, alu_young_d;
  logic [AW-1:0] alu_addr_q, alu_addr_d;
  logic [DW-1:0] alu_data_q, alu_data_d;
  logic          dm_full_q, dm_full_d, dm_young_q, dm_young_d;
  logic [AW-1:0] dm_addr_q, dm_addr_d;
  logic [DW-1:0] dm_data_q, dm_data_d;
  src_e          rr_q, rr_d;
  logic          wb_en_q, wb_en_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          both_full, grant_alu, grant_dm, grant_any;
  logic          alu_accept, dm_accept;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;

  assign both_full = alu_full_q & dm_full_q;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant_alu = 1'b0;
    grant_dm  = 1'b0;
    if (both_full) begin
      if (alu_addr_q == dm_addr_q) begin
        // Same destination: write in arrival order; simultaneous loads favour DM.
        if (dm_young_q && !alu_young_q) grant_alu = 1'b1;
        else                            grant_dm  = 1'b1;
      end else if (rr_q == SRC_ALU) begin
        grant_alu = 1'b1;
      end else begin
        grant_dm = 1'b1;
      end
    end else begin
      grant_alu = alu_full_q;
      grant_dm  = dm_full_q;
    end
  end

  assign grant_any  = grant_alu | grant_dm;
  assign gnt_addr   = grant_dm ? dm_addr_q : alu_addr_q;
  assign gnt_data   = grant_dm ? dm_data_q : alu_data_q;
  assign alu_ready  = ~reset & (~alu_full_q | grant_alu);
  assign dm_ready   = ~reset & (~dm_full_q | grant_dm);
  assign alu_accept = alu_valid & alu_ready;
  assign dm_accept  = dm_valid & dm_ready;

  always_comb begin
    alu_full_d  = alu_full_q;
    alu_addr_d  = alu_addr_q;
    alu_data_d  = alu_data_q;
    alu_young_d = alu_young_q;
    dm_full_d   = dm_full_q;
    dm_addr_d   = dm_addr_q;
    dm_data_d   = dm_data_q;
    dm_young_d  = dm_young_q;

    // The other side draining makes this entry the oldest one left.
    if (grant_dm)  alu_young_d = 1'b0;
    if (grant_alu) dm_young_d  = 1'b0;
    if (grant_alu) begin
      alu_full_d  = 1'b0;
      alu_young_d = 1'b0;
    end
    if (grant_dm) begin
      dm_full_d  = 1'b0;
      dm_young_d = 1'b0;
    end
    if (alu_accept) begin
      alu_full_d  = 1'b1;
      alu_addr_d  = alu_addr;
      alu_data_d  = alu_data;
      alu_young_d = dm_full_q & ~grant_dm;
    end
    if (dm_accept) begin
      dm_full_d  = 1'b1;
      dm_addr_d  = dm_addr;
      dm_data_d  = dm_data;
      dm_young_d = alu_full_q & ~grant_alu;
    end

    rr_d = rr_q;
    if (both_full) rr_d = grant_alu ? SRC_DM : SRC_ALU;

    cnt_d = cnt_q;
    if (both_full && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;

    // r0 is hardwired: its entry is consumed but never written.
    wb_en_d   = grant_any && (gnt_addr != '0);
    wb_addr_d = grant_any ? gnt_addr : wb_addr_q;
    wb_data_d = grant_any ? gnt_data : wb_data_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      alu_full_q  <= 1'b0;
      alu_addr_q  <= '0;
      alu_data_q  <= '0;
      alu_young_q <= 1'b0;
      dm_full_q   <= 1'b0;
      dm_addr_q   <= '0;
      dm_data_q   <= '0;
      dm_young_q  <= 1'b0;
      rr_q        <= SRC_ALU;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      cnt_q       <= '0;
    end else begin
      alu_full_q  <= alu_full_d;
      alu_addr_q  <= alu_addr_d;
      alu_data_q  <= alu_data_d;
      alu_young_q <= alu_young_d;
      dm_full_q   <= dm_full_d;
      dm_addr_q   <= dm_addr_d;
      dm_data_q   <= dm_data_d;
      dm_young_q  <= dm_young_d;
      rr_q        <= rr_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    pend_mask = '0;
    if (alu_full_q) pend_mask[alu_addr_q] = 1'b1;
    if (dm_full_q)  pend_mask[dm_addr_q]  = 1'b1;
    pend_mask[0] = 1'b0;
  end

  assign wb_en        = wb_en_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: per-cycle vector table through a
// scoreboard queue, then a long-contention run for counter saturation.
module tb_wb_port_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alu_valid = 1'b0, dm_valid = 1'b0;
  logic [2:0] alu_addr = '0, dm_addr = '0;
  logic [7:0] alu_data = '0, dm_data = '0;
  logic       alu_ready, dm_ready, wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data, pend_mask, conflict_cnt;

  wb_port_arbiter #(.DW(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .dm_valid(dm_valid), .dm_addr(dm_addr), .dm_data(dm_data), .dm_ready(dm_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pend_mask(pend_mask), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Inputs for one cycle; ready expected just before the edge, rest just after it.
  typedef struct {
    logic       rst, av;
    logic [2:0] aa;
    logic [7:0] ad;
    logic       dv;
    logic [2:0] da;
    logic [7:0] dd;
    logic       ar, dr, en;
    logic [2:0] wa;
    logic [7:0] wd, pm, cc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec = 0, n_cmp = 0, n_fail = 0;
  logic ar_s, dr_s;

  task automatic v(input logic rst, av, input logic [2:0] aa, input logic [7:0] ad,
                   input logic dv, input logic [2:0] da, input logic [7:0] dd,
                   input logic ar, dr, en, input logic [2:0] wa,
                   input logic [7:0] wd, pm, cc);
    vecs.push_back('{rst, av, aa, ad, dv, da, dd, ar, dr, en, wa, wd, pm, cc});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    //  rst av aa ad     dv da dd     ar dr en wa wd     pm     cc
    v(1, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0); // reset
    v(1, 1'b1, 3, 8'h77, 1'b0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0); // ignored during reset
    v(0, 1'b1, 3, 8'h5A, 1'b0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h08, 0); // single ALU
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 1, 3, 8'h5A, 8'h00, 0);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 0, 3, 8'h5A, 8'h00, 0);
    v(0, 1'b1, 2, 8'h11, 1'b1, 5, 8'h22, 1, 1, 0, 3, 8'h5A, 8'h24, 0); // contention, rr=0
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 0, 1, 2, 8'h11, 8'h20, 1);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 1, 5, 8'h22, 8'h00, 1);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 0, 5, 8'h22, 8'h00, 1);
    v(0, 1'b1, 1, 8'h33, 1'b1, 6, 8'h44, 1, 1, 0, 5, 8'h22, 8'h42, 1); // contention, rr=1
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 0, 1, 1, 6, 8'h44, 8'h02, 2);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 1, 1, 8'h33, 8'h00, 2);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 0, 1, 8'h33, 8'h00, 2);
    v(0, 1'b1, 4, 8'hBB, 1'b1, 4, 8'hAA, 1, 1, 0, 1, 8'h33, 8'h10, 2); // same addr, same edge
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 0, 1, 1, 4, 8'hAA, 8'h10, 3);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 1, 4, 8'hBB, 8'h00, 3);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 0, 4, 8'hBB, 8'h00, 3);
    v(0, 1'b1, 1, 8'h01, 1'b1, 2, 8'h02, 1, 1, 0, 4, 8'hBB, 8'h06, 3); // ALU refills younger
    v(0, 1'b1, 2, 8'h03, 1'b0, 0, 8'h00, 1, 0, 1, 1, 8'h01, 8'h04, 4);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 0, 1, 1, 2, 8'h02, 8'h04, 5);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 1, 2, 8'h03, 8'h00, 5);
    v(0, 1'b1, 3, 8'h10, 1'b1, 5, 8'h20, 1, 1, 0, 2, 8'h03, 8'h28, 5); // DM refills younger
    v(0, 1'b1, 6, 8'h11, 1'b0, 0, 8'h00, 1, 0, 1, 3, 8'h10, 8'h60, 6);
    v(0, 1'b0, 0, 8'h00, 1'b1, 6, 8'h21, 0, 1, 1, 5, 8'h20, 8'h40, 7);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 0, 1, 6, 8'h11, 8'h40, 8);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 1, 6, 8'h21, 8'h00, 8);
    v(0, 1'b1, 0, 8'hFF, 1'b0, 0, 8'h00, 1, 1, 0, 6, 8'h21, 8'h00, 8); // r0 write
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 0, 0, 8'hFF, 8'h00, 8);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 0, 0, 8'hFF, 8'h00, 8);
    v(0, 1'b1, 7, 8'h01, 1'b0, 0, 8'h00, 1, 1, 0, 0, 8'hFF, 8'h80, 8); // streaming
    v(0, 1'b1, 7, 8'h02, 1'b0, 0, 8'h00, 1, 1, 1, 7, 8'h01, 8'h80, 8);
    v(0, 1'b1, 7, 8'h03, 1'b0, 0, 8'h00, 1, 1, 1, 7, 8'h02, 8'h80, 8);
    v(0, 1'b1, 7, 8'h04, 1'b0, 0, 8'h00, 1, 1, 1, 7, 8'h03, 8'h80, 8);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 1, 7, 8'h04, 8'h00, 8);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 0, 7, 8'h04, 8'h00, 8);
    v(0, 1'b1, 1, 8'h55, 1'b1, 2, 8'h66, 1, 1, 0, 7, 8'h04, 8'h06, 8); // reset mid-flight
    v(1, 1'b1, 3, 8'h99, 1'b1, 4, 8'h88, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00, 0);
    v(0, 1'b1, 3, 8'h01, 1'b1, 4, 8'h02, 1, 1, 0, 0, 8'h00, 8'h18, 0); // rr back to ALU
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 0, 1, 3, 8'h01, 8'h10, 1);
    v(0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1, 1, 1, 4, 8'h02, 8'h00, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
      dm_valid = vecs[i].dv;  dm_addr = vecs[i].da;  dm_data = vecs[i].dd;
      sb.push_back(vecs[i]);
      #1;
      ar_s = alu_ready;
      dr_s = dm_ready;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_vec++;
      check($sformatf("v%0d alu_ready", i), 32'(ar_s), 32'(e.ar));
      check($sformatf("v%0d dm_ready", i), 32'(dr_s), 32'(e.dr));
      check($sformatf("v%0d wb_en", i), 32'(wb_en), 32'(e.en));
      check($sformatf("v%0d wb_addr", i), 32'(wb_addr), 32'(e.wa));
      check($sformatf("v%0d wb_data", i), 32'(wb_data), 32'(e.wd));
      check($sformatf("v%0d pend_mask", i), 32'(pend_mask), 32'(e.pm));
      check($sformatf("v%0d conflict_cnt", i), 32'(conflict_cnt), 32'(e.cc));
    end

    // Saturation: both sources held valid keep both buffers full every cycle.
    @(negedge clk);
    reset = 1'b1;
    alu_valid = 1'b0;
    dm_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 8'hC1;
    dm_valid = 1'b1;  dm_addr = 3'd2;  dm_data = 8'hD2;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (k == 100) begin
        n_vec++;
        check("sat cnt@100", 32'(conflict_cnt), 32'd99);
      end
    end
    n_vec++;
    check("sat cnt@300", 32'(conflict_cnt), 32'd255);
    check("sat wb_en", 32'(wb_en), 32'd1);
    check("sat pend_mask", 32'(pend_mask), 32'h06);
    alu_valid = 1'b0;
    dm_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DW, default 8, data width of register-file write data.
REQ-002 Parameter AW, default 3, register address width (2**AW registers).
REQ-003 clk  input  1  single clock, all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 alu_valid  input  1  ALU result request valid.
REQ-006 alu_addr  input  AW  ALU destination register.
REQ-007 alu_data  input  DW  ALU result.
REQ-008 alu_ready  output  1  ALU request accepted this cycle when alu_valid is also high.
REQ-009 dm_valid  input  1  data-memory load result request valid.
REQ-010 dm_addr  input  AW  load destination register.
REQ-011 dm_data  input  DW  load data.
REQ-012 dm_ready  output  1  load request accepted this cycle when dm_valid is also high.
REQ-013 wb_en  output  1  registered register-file write enable.
REQ-014 wb_addr  output  AW  registered write address.
REQ-015 wb_data  output  DW  registered write data.
REQ-016 pend_mask  output  2**AW  bit i high when a buffered, not yet written request targets register i.
REQ-017 conflict_cnt  output  8  saturating count of cycles in which both buffers competed for the port.

Function
REQ-018 Each source SHALL own a 1-entry holding buffer (full flag, addr, data, age tag).
REQ-019 A source handshake SHALL complete when valid and ready are both high at a posedge; the buffer loads on that edge.
REQ-020 x_ready SHALL equal (not full_x) or grant_x, and SHALL be low while reset is high; a buffer may drain and refill on the same edge.
REQ-021 Each cycle at most one full buffer SHALL be granted; the granted entry SHALL appear on wb_addr/wb_data at the next edge and its buffer SHALL clear on that edge unless refilled.
REQ-022 Latency: request accepted at edge N into an empty, uncontested buffer SHALL produce wb_en at edge N+1.
REQ-023 With only one buffer full, that buffer SHALL be granted.
REQ-024 With both buffers full and equal addresses, the older entry SHALL be granted; if both loaded on the same edge, DM is older.
REQ-025 With both full and different addresses, the round-robin pointer rr (0 = ALU, 1 = DM) SHALL choose; after a contested grant rr SHALL point to the losing source.
REQ-026 wb_en SHALL be high the cycle after a grant, except when the granted address is 0 (r0 hardwired), in which case wb_en SHALL be 0 while the entry is still consumed.
REQ-027 wb_en SHALL be 0 in any cycle following a cycle with no grant; wb_addr/wb_data SHALL hold their last values.
REQ-028 pend_mask SHALL be the OR of decoded addresses of full buffers, bit 0 forced 0, computed from registered state.
REQ-029 conflict_cnt SHALL increment in each cycle both buffers are full and saturate at 255.
REQ-030 Age tag: a buffer loaded while the other is already full SHALL be marked younger; the tag SHALL clear when the other buffer drains.

Reset
REQ-031 On a posedge with reset high: both buffers empty, wb_en=0, wb_addr=0, wb_data=0, rr=0, pend_mask=0, conflict_cnt=0.
REQ-032 Reset mid-operation SHALL discard buffered entries without producing any write; handshakes presented during reset SHALL not be accepted.

Verification
REQ-033 Single ALU: alu_valid=1, addr=3, data=8'h5A at edge N -> wb_en=1, wb_addr=3, wb_data=8'h5A after edge N+1; pend_mask=8'b0000_1000 for one cycle.
REQ-034 Contention, different addresses: ALU(2,8'h11) and DM(5,8'h22) same edge, rr=0 -> write r2 then r5 on consecutive cycles; conflict_cnt=1; rr=1 afterwards.
REQ-035 Same address: DM(4,8'hAA) and ALU(4,8'hBB) same edge -> r4=8'hAA written first, then 8'hBB; final value 8'hBB.
REQ-036 r0 write: ALU(0,8'hFF) -> entry consumed, wb_en stays 0, pend_mask stays 0, alu_ready returns high.
REQ-037 Back-to-back streaming: alu_valid held high 4 cycles, data 1..4, dm idle -> 4 consecutive wb_en pulses, alu_ready never low.
REQ-038 Reset mid-flight: both buffers full, reset pulsed one cycle -> no wb_en, pend_mask=0, conflict_cnt=0, rr=0 next cycle.
